// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the IF/data memory port arbiter.
// Grant FSM encoding and latency-counter sizing helper.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'b00,
    ARB_BUSY_IF = 2'b01,
    ARB_BUSY_D  = 2'b10
  } arb_state_t;

  function automatic int cnt_w(input int lat);
    return $clog2(lat) + 1;
  endfunction

endpackage

// File: rtl/mem_lat_counter.sv
// Load/decrement latency counter for the memory arbiter.
// Flags zero in the cycle the memory read data is valid.
module mem_lat_counter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-ported memory shared by instruction fetch and data access.
// Data wins ties; a port is ineligible in its own ack cycle.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int CW = cnt_w(MEM_LAT);
  localparam logic [CW-1:0] LOAD = CW'(MEM_LAT - 1);

  arb_state_t state;
  arb_state_t state_n;
  logic d_ok;
  logic if_ok;
  logic grant_d;
  logic grant_if;
  logic done;
  logic zero;
  logic we_q;

  assign d_ok  = d_req & ~d_ack;
  assign if_ok = if_req & ~if_ack;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ARB_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      ARB_IDLE: begin
        if (d_ok) begin
          state_n = ARB_BUSY_D;
        end else if (if_ok) begin
          state_n = ARB_BUSY_IF;
        end
      end
      ARB_BUSY_IF,
      ARB_BUSY_D: begin
        if (zero) begin
          state_n = ARB_IDLE;
        end
      end
      default: state_n = ARB_IDLE;
    endcase
  end

  always_comb begin
    busy     = (state != ARB_IDLE);
    grant_d  = (state == ARB_IDLE) & d_ok;
    grant_if = (state == ARB_IDLE) & ~d_ok & if_ok;
    done     = busy & zero;
  end

  mem_lat_counter #(
    .W(CW)
  ) u_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (grant_d | grant_if),
    .load_val(LOAD),
    .dec     (busy & ~zero),
    .zero    (zero)
  );

  // Request latches; address and store data hold while idle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      we_q      <= 1'b0;
    end else begin
      mem_en <= grant_d | grant_if;
      mem_we <= grant_d & d_we;
      if (grant_d) begin
        mem_addr  <= d_addr;
        mem_wdata <= d_wdata;
        we_q      <= d_we;
      end else if (grant_if) begin
        mem_addr <= if_addr;
        we_q     <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      if_ack   <= 1'b0;
      d_ack    <= 1'b0;
      if_rdata <= '0;
      d_rdata  <= '0;
    end else begin
      if_ack <= done & (state == ARB_BUSY_IF);
      d_ack  <= done & (state == ARB_BUSY_D);
      if (done && state == ARB_BUSY_IF) begin
        if_rdata <= mem_rdata;
      end
      if (done && state == ARB_BUSY_D && !we_q) begin
        d_rdata <= mem_rdata;
      end
    end
  end

endmodule
